flag_cond_unit: RTL and testbench
=================================

Name: flag_cond_unit

Overview:
- Consumer side of the 32-bit add/sub flag outputs (CF, OF, ZF, SF, PF).
- Latches the flags into an architectural flag register.
- Evaluates the 16 x86-style condition codes against the register, with a registered result.
- Provides a small push/pop flag stack for save/restore across calls and interrupts.
- Sits between the ALU and the branch/sequencer logic.

Parameters:
- STACK_DEPTH, 4, number of 5-bit flag-stack entries; power of two, range 2..16.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous active-high reset.
- flag_we  input  1  load CF_in..PF_in into the flag register this cycle.
- CF_in  input  1  carry/borrow flag from the adder.
- OF_in  input  1  signed overflow flag from the adder.
- ZF_in  input  1  zero flag from the adder.
- SF_in  input  1  sign flag from the adder.
- PF_in  input  1  parity flag from the adder, used as delivered.
- cond_req  input  1  request evaluation of cond_code.
- cond_code  input  4  condition selector.
- taken  output  1  condition result; valid when taken_valid=1.
- taken_valid  output  1  one-cycle pulse, one cycle after cond_req.
- flags_out  output  5  flag register {CF,OF,ZF,SF,PF}, bit4=CF.
- push  input  1  push flag register onto the stack.
- pop  input  1  pop the top of the stack into the flag register.
- stack_empty  output  1  stack count = 0.
- stack_full  output  1  stack count = STACK_DEPTH.
- stack_err  output  1  one-cycle pulse on an illegal stack operation.

Behaviour:
- Reset: flags_out=0, stack count=0, taken=0, taken_valid=0, stack_err=0, stack_empty=1, stack_full=0. Stack storage contents are don't-care.
- Flag register load: on flag_we, flags_out takes {CF_in,OF_in,ZF_in,SF_in,PF_in} on the next edge.
- Condition evaluation: on cond_req, taken and taken_valid are registered with 1-cycle latency. Evaluation uses the flag register value before any same-cycle update.
- Back-to-back cond_req is allowed every cycle. taken holds its value when taken_valid=0.
- Condition codes (codes 0..F):
  - 0 O: OF; 1 NO: ~OF.
  - 2 B: CF; 3 AE: ~CF.
  - 4 E: ZF; 5 NE: ~ZF.
  - 6 BE: CF|ZF; 7 A: ~(CF|ZF).
  - 8 S: SF; 9 NS: ~SF.
  - A P: PF; B NP: ~PF.
  - C L: SF^OF; D GE: ~(SF^OF).
  - E LE: ZF|(SF^OF); F G: ~(ZF|(SF^OF)).
- Stack FSM: EMPTY (count=0), PARTIAL (0<count<DEPTH), FULL (count=DEPTH). Transitions occur on a legal push (count+1) or a legal pop (count-1).
- Push: writes the pre-update flag register to entry[count]; count increments. A same-cycle flag_we still loads the register, and the stack receives the old value.
- Pop: loads entry[count-1] into the flag register; count decrements. Pop has priority over flag_we, and the same-cycle flag_we is discarded.
- Push when FULL: ignored, stack unchanged, stack_err=1 for one cycle.
- Pop when EMPTY: ignored, flag register unchanged, stack_err=1 for one cycle. A same-cycle flag_we still applies.
- Push and pop in the same cycle: both ignored, stack_err=1. A same-cycle flag_we still applies.
- cond_req in the same cycle as a pop: evaluated on the pre-pop register value.
- Reset mid-operation: rst overrides all inputs that cycle. A pending taken_valid is cleared, and the stack is emptied.

Optional Feature:
- Macro: FLAG_COND_BYPASS_EN.
- Defined: when cond_req and flag_we coincide (and no legal pop that cycle), the condition is evaluated on the incoming CF_in..PF_in. This lets a compare-and-branch resolve in one cycle.
- Undefined: evaluation always uses the registered flags, as specified above.
- Latency is 1 cycle in both builds.

Test Plan:
- Reset then cond_req code 4 (E) -> next cycle taken_valid=1, taken=0; flags_out=5'b00000, stack_empty=1.
- flag_we with CF=1,ZF=0 (flags 5'b10000), next cycle cond_req code 2/6/7 -> taken=1/1/0 on successive cycles.
- Flags SF=1,OF=0, then codes C/D/E/F -> taken=1,0,1,0; then SF=1,OF=1 gives code C -> 0, code F -> 1 (ZF=0).
- Push 4 distinct patterns 5'h01,5'h02,5'h04,5'h08 (DEPTH=4) -> stack_full=1. A 5th push -> stack_err pulse, count unchanged. Four pops restore flags 5'h08,5'h04,5'h02,5'h01 in order, then stack_empty=1. A 5th pop -> stack_err, flags stay 5'h01.
- Same-cycle flag_we (5'h1F) with push, flags previously 5'h03 -> flags_out=5'h1F, and a later pop restores 5'h03. Same-cycle pop and flag_we -> flag_we discarded. Same-cycle push and pop -> stack_err, count unchanged.
- flags 5'h00, cond_req code 4 with flag_we ZF=1 in the same cycle -> taken=0 without FLAG_COND_BYPASS_EN, taken=1 with it. Asserting rst while taken_valid is pending -> taken_valid=0 next cycle.

Source files
------------

// File: rtl/flag_cond_if.sv
// Flag/condition/stack bundle between the ALU, the flag unit and the
// branch sequencer.
interface flag_cond_if;
   logic       flag_we;
   logic       CF_in;
   logic       OF_in;
   logic       ZF_in;
   logic       SF_in;
   logic       PF_in;
   logic       cond_req;
   logic [3:0] cond_code;
   logic       taken;
   logic       taken_valid;
   logic [4:0] flags_out;
   logic       push;
   logic       pop;
   logic       stack_empty;
   logic       stack_full;
   logic       stack_err;

   modport master (
      output flag_we, CF_in, OF_in, ZF_in, SF_in, PF_in,
      output cond_req, cond_code, push, pop,
      input  taken, taken_valid, flags_out,
      input  stack_empty, stack_full, stack_err
   );

   modport slave (
      input  flag_we, CF_in, OF_in, ZF_in, SF_in, PF_in,
      input  cond_req, cond_code, push, pop,
      output taken, taken_valid, flags_out,
      output stack_empty, stack_full, stack_err
   );
endinterface

// File: rtl/flag_cond_unit.sv
// Flag register, x86 condition evaluator and push/pop flag stack.
// Define FLAG_COND_BYPASS_EN to evaluate conditions on same-cycle incoming flags.
module flag_cond_unit #(
   parameter int STACK_DEPTH = 4
) (
   input logic       clk,
   input logic       rst,
   flag_cond_if.slave bus
);
   localparam int AW = $clog2(STACK_DEPTH);
   localparam logic [AW:0] DEPTH_C = STACK_DEPTH[AW:0];

   localparam logic [1:0] ST_EMPTY = 2'd0;
   localparam logic [1:0] ST_PART  = 2'd1;
   localparam logic [1:0] ST_FULL  = 2'd2;

   logic [1:0]  state, state_nx;
   logic [AW:0] count, count_nx, count_m1;
   logic [4:0]  flags;
   logic [4:0]  stack [STACK_DEPTH];
   logic [4:0]  flags_in, eval_src;
   logic        taken, taken_valid, err;
   logic        push_ok, pop_ok, err_nx, cond_res;

   assign flags_in = {bus.CF_in, bus.OF_in, bus.ZF_in,
                      bus.SF_in, bus.PF_in};
   assign count_m1 = count - 1'b1;

   assign push_ok = bus.push & ~bus.pop & (state != ST_FULL);
   assign pop_ok  = bus.pop & ~bus.push & (state != ST_EMPTY);
   assign err_nx  = (bus.push & bus.pop)
                  | (bus.push & ~bus.pop & (state == ST_FULL))
                  | (bus.pop & ~bus.push & (state == ST_EMPTY));

`ifdef FLAG_COND_BYPASS_EN
   assign eval_src = (bus.flag_we & ~pop_ok) ? flags_in : flags;
`else
   assign eval_src = flags;
`endif

   // eval_src layout: {CF,OF,ZF,SF,PF}
   always_comb begin
      cond_res = 1'b0;
      unique case (bus.cond_code)
         4'h0: cond_res =  eval_src[3];
         4'h1: cond_res = ~eval_src[3];
         4'h2: cond_res =  eval_src[4];
         4'h3: cond_res = ~eval_src[4];
         4'h4: cond_res =  eval_src[2];
         4'h5: cond_res = ~eval_src[2];
         4'h6: cond_res =  (eval_src[4] | eval_src[2]);
         4'h7: cond_res = ~(eval_src[4] | eval_src[2]);
         4'h8: cond_res =  eval_src[1];
         4'h9: cond_res = ~eval_src[1];
         4'hA: cond_res =  eval_src[0];
         4'hB: cond_res = ~eval_src[0];
         4'hC: cond_res =  (eval_src[1] ^ eval_src[3]);
         4'hD: cond_res = ~(eval_src[1] ^ eval_src[3]);
         4'hE: cond_res =  (eval_src[2] | (eval_src[1] ^ eval_src[3]));
         4'hF: cond_res = ~(eval_src[2] | (eval_src[1] ^ eval_src[3]));
         default: cond_res = 1'b0;
      endcase
   end

   always_comb begin
      count_nx = count;
      if (push_ok)
         count_nx = count + 1'b1;
      else if (pop_ok)
         count_nx = count_m1;
      if (count_nx == '0)
         state_nx = ST_EMPTY;
      else if (count_nx == DEPTH_C)
         state_nx = ST_FULL;
      else
         state_nx = ST_PART;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= ST_EMPTY;
         count       <= '0;
         flags       <= '0;
         taken       <= 1'b0;
         taken_valid <= 1'b0;
         err         <= 1'b0;
      end else begin
         state       <= state_nx;
         count       <= count_nx;
         taken_valid <= bus.cond_req;
         err         <= err_nx;
         if (bus.cond_req)
            taken <= cond_res;
         // a legal pop wins over a same-cycle flag load
         if (pop_ok)
            flags <= stack[count_m1[AW-1:0]];
         else if (bus.flag_we)
            flags <= flags_in;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst && push_ok)
         stack[count[AW-1:0]] <= flags;
   end

   assign bus.flags_out   = flags;
   assign bus.taken       = taken;
   assign bus.taken_valid = taken_valid;
   assign bus.stack_err   = err;
   assign bus.stack_empty = (state == ST_EMPTY);
   assign bus.stack_full  = (state == ST_FULL);
endmodule

// File: tb/tb_flag_cond_unit.sv
// Randomized and directed bench for flag_cond_unit against a queue-based
// reference model.
module tb_flag_cond_unit;
   localparam int DEPTH = 4;

   logic clk = 1'b0;
   logic rst;
   int   n_cmp = 0;
   int   n_bad = 0;

   flag_cond_if bus ();

   flag_cond_unit #(.STACK_DEPTH(DEPTH)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   logic [4:0] m_flags;
   logic [4:0] m_q[$];
   logic       m_taken, m_tv, m_err;

   function automatic logic ref_cond(logic [4:0] f, logic [3:0] c);
      bit cf, of, zf, sf, pf, lt, r;
      cf = f[4]; of = f[3]; zf = f[2]; sf = f[1]; pf = f[0];
      lt = (sf != of);
      case (c >> 1)
         0: r = of;
         1: r = cf;
         2: r = zf;
         3: r = cf || zf;
         4: r = sf;
         5: r = pf;
         6: r = lt;
         default: r = zf || lt;
      endcase
      return c[0] ? !r : r;
   endfunction

   task automatic drive(input bit r, input bit we, input logic [4:0] f,
                        input bit cr, input logic [3:0] code,
                        input bit pu, input bit po);
      rst = r;
      bus.flag_we = we;
      {bus.CF_in, bus.OF_in, bus.ZF_in, bus.SF_in, bus.PF_in} = f;
      bus.cond_req = cr;
      bus.cond_code = code;
      bus.push = pu;
      bus.pop = po;
   endtask

   // advance one clock and update the model from the inputs held this cycle
   task automatic cycle();
      logic [4:0] inf, src, nf;
      bit legal_pop;
      inf = {bus.CF_in, bus.OF_in, bus.ZF_in, bus.SF_in, bus.PF_in};
      nf = m_flags;
      if (rst) begin
         m_q.delete();
         nf = 0; m_taken = 0; m_tv = 0; m_err = 0;
      end else begin
         legal_pop = bus.pop && !bus.push && m_q.size() > 0;
         src = m_flags;
`ifdef FLAG_COND_BYPASS_EN
         if (bus.flag_we && !legal_pop) src = inf;
`endif
         m_tv = bus.cond_req;
         if (bus.cond_req) m_taken = ref_cond(src, bus.cond_code);
         m_err = 0;
         if (bus.push && bus.pop) m_err = 1;
         else if (bus.push) begin
            if (m_q.size() == DEPTH) m_err = 1;
            else m_q.push_back(m_flags);
         end else if (bus.pop) begin
            if (m_q.size() == 0) m_err = 1;
         end
         if (legal_pop) nf = m_q.pop_back();
         else if (bus.flag_we) nf = inf;
      end
      @(posedge clk);
      #1;
      m_flags = nf;
   endtask

   function automatic logic [9:0] model_vec();
      return {m_tv, m_taken, m_flags, m_q.size() == 0,
              m_q.size() == DEPTH, m_err};
   endfunction

   function automatic logic [9:0] dut_vec();
      return {bus.taken_valid, bus.taken, bus.flags_out,
              bus.stack_empty, bus.stack_full, bus.stack_err};
   endfunction

   task automatic test_reset();
      drive(1, 0, 0, 0, 0, 0, 0);
      cycle(); cycle();
      drive(0, 0, 0, 1, 4'h4, 0, 0);
      cycle();
      n_cmp++;
      if (dut_vec() !== {1'b1, 1'b0, 5'h00, 1'b1, 1'b0, 1'b0}) begin
         n_bad++;
         $display("FAIL reset_cond_e got=%b exp=%b", dut_vec(),
                  {1'b1, 1'b0, 5'h00, 1'b1, 1'b0, 1'b0});
      end
   endtask

   task automatic test_cond_codes();
      logic [3:0] codes[10];
      logic [4:0] fl[10];
      logic       exp[10];
      codes = '{4'h2, 4'h6, 4'h7, 4'hC, 4'hD, 4'hE, 4'hF, 4'hC, 4'hF, 4'hA};
      fl    = '{5'h10, 5'h10, 5'h10, 5'h02, 5'h02, 5'h02, 5'h02,
                5'h0A, 5'h0A, 5'h0A};
      exp   = '{1, 1, 0, 1, 0, 1, 0, 0, 1, 0};
      for (int i = 0; i < 10; i++) begin
         drive(0, 1, fl[i], 0, 0, 0, 0);
         cycle();
         drive(0, 0, 0, 1, codes[i], 0, 0);
         cycle();
         n_cmp++;
         if (bus.taken_valid !== 1'b1 || bus.taken !== exp[i] ||
             bus.taken !== m_taken) begin
            n_bad++;
            $display("FAIL cond_%0d code=%h got=%b exp=%b", i, codes[i],
                     bus.taken, exp[i]);
         end
      end
      drive(0, 0, 0, 0, 0, 0, 0);
      cycle();
      n_cmp++;
      if (bus.taken_valid !== 1'b0 || bus.taken !== m_taken) begin
         n_bad++;
         $display("FAIL taken_hold got=%b/%b exp=0/%b", bus.taken_valid,
                  bus.taken, m_taken);
      end
   endtask

   task automatic test_stack();
      logic [4:0] pat[4];
      pat = '{5'h01, 5'h02, 5'h04, 5'h08};
      drive(0, 1, pat[0], 0, 0, 0, 0);
      cycle();
      for (int i = 1; i < 4; i++) begin
         drive(0, 1, pat[i], 0, 0, 1, 0);
         cycle();
      end
      drive(0, 0, 0, 0, 0, 1, 0);
      cycle();
      n_cmp++;
      if (bus.stack_full !== 1'b1 || bus.stack_err !== 1'b0) begin
         n_bad++;
         $display("FAIL stack_full got=%b err=%b exp=1", bus.stack_full,
                  bus.stack_err);
      end
      cycle();
      n_cmp++;
      if (bus.stack_err !== 1'b1 || bus.stack_full !== 1'b1) begin
         n_bad++;
         $display("FAIL push_when_full err=%b full=%b exp=1/1",
                  bus.stack_err, bus.stack_full);
      end
      for (int i = 3; i >= 0; i--) begin
         drive(0, 0, 0, 0, 0, 0, 1);
         cycle();
         n_cmp++;
         if (bus.flags_out !== pat[i] || bus.stack_err !== 1'b0) begin
            n_bad++;
            $display("FAIL pop_%0d got=%h exp=%h", i, bus.flags_out, pat[i]);
         end
      end
      n_cmp++;
      if (bus.stack_empty !== 1'b1) begin
         n_bad++;
         $display("FAIL empty_after_pops got=%b exp=1", bus.stack_empty);
      end
      cycle();
      n_cmp++;
      if (bus.stack_err !== 1'b1 || bus.flags_out !== 5'h01) begin
         n_bad++;
         $display("FAIL pop_when_empty err=%b flags=%h exp=1/01",
                  bus.stack_err, bus.flags_out);
      end
   endtask

   task automatic test_same_cycle();
      drive(0, 1, 5'h03, 0, 0, 0, 0);
      cycle();
      drive(0, 1, 5'h1F, 0, 0, 1, 0);
      cycle();
      n_cmp++;
      if (bus.flags_out !== 5'h1F) begin
         n_bad++;
         $display("FAIL we_with_push got=%h exp=1f", bus.flags_out);
      end
      drive(0, 1, 5'h15, 0, 0, 0, 1);
      cycle();
      n_cmp++;
      if (bus.flags_out !== 5'h03 || bus.stack_empty !== 1'b1) begin
         n_bad++;
         $display("FAIL pop_over_we got=%h exp=03", bus.flags_out);
      end
      drive(0, 0, 0, 0, 0, 1, 0);
      cycle();
      drive(0, 1, 5'h0C, 0, 0, 1, 1);
      cycle();
      n_cmp++;
      if (bus.stack_err !== 1'b1 || bus.flags_out !== 5'h0C ||
          bus.stack_empty !== 1'b0 || bus.stack_full !== 1'b0) begin
         n_bad++;
         $display("FAIL push_pop_same got=%b exp=err,flags0c",
                  dut_vec());
      end
      drive(0, 0, 0, 0, 0, 0, 1);
      cycle();
      n_cmp++;
      if (bus.flags_out !== 5'h03 || bus.stack_empty !== 1'b1) begin
         n_bad++;
         $display("FAIL count_kept got=%h exp=03", bus.flags_out);
      end
   endtask

   task automatic test_bypass();
      logic exp;
`ifdef FLAG_COND_BYPASS_EN
      exp = 1'b1;
`else
      exp = 1'b0;
`endif
      drive(0, 1, 5'h00, 0, 0, 0, 0);
      cycle();
      drive(0, 1, 5'h04, 1, 4'h4, 0, 0);
      cycle();
      n_cmp++;
      if (bus.taken_valid !== 1'b1 || bus.taken !== exp) begin
         n_bad++;
         $display("FAIL bypass got=%b exp=%b", bus.taken, exp);
      end
   endtask

   task automatic test_rst_mid();
      drive(0, 1, 5'h1F, 1, 4'h0, 1, 0);
      cycle();
      drive(1, 0, 0, 1, 4'h1, 1, 0);
      cycle();
      n_cmp++;
      if (dut_vec() !== {1'b0, 1'b0, 5'h00, 1'b1, 1'b0, 1'b0}) begin
         n_bad++;
         $display("FAIL rst_mid got=%b exp=%b", dut_vec(),
                  {1'b0, 1'b0, 5'h00, 1'b1, 1'b0, 1'b0});
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 400; i++) begin
         drive($urandom_range(0, 49) == 0, $urandom_range(0, 1),
               5'($urandom), $urandom_range(0, 1), 4'($urandom),
               $urandom_range(0, 3) == 0, $urandom_range(0, 4) == 0);
         cycle();
         n_cmp++;
         if (dut_vec() !== model_vec()) begin
            n_bad++;
            $display("FAIL random_%0d got=%b exp=%b", i, dut_vec(),
                     model_vec());
         end
      end
   endtask

   initial begin
      m_flags = 0; m_taken = 0; m_tv = 0; m_err = 0;
      drive(1, 0, 0, 0, 0, 0, 0);
      test_reset();
      test_cond_codes();
      test_stack();
      test_same_cycle();
      test_bypass();
      test_rst_mid();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
